// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: owns the fetch PC, drives the combinational instruction memory,
// and buffers fetched {pc, inst} pairs in a small FIFO toward decode.
// Handles decode back-pressure, branch/jump redirects and out-of-range fetches.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 2,
   parameter int          MEM_WORDS = 1001,
   parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_ce,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc
);

   localparam int               PTR_W       = $clog2(DEPTH);
   localparam int               CNT_W       = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
   localparam logic [31:0]      MEM_WORDS_C = 32'(MEM_WORDS);

   // IDLE is the single bubble cycle after reset; FETCH is normal operation.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              w_fetch_st;

   logic [31:0]       r_fpc;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;

   logic [31:0]       r_buf_pc   [DEPTH];
   logic [31:0]       r_buf_inst [DEPTH];

   logic              w_pop;
   logic              w_fetch_ok;
   logic              w_in_range;
   logic [31:0]       w_push_inst;
   logic [31:0]       w_redir_target;

   logic              r_chk_vld;
   logic [31:0]       r_chk_pc;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state: IDLE always falls through to FETCH, FETCH is absorbing.
   always_comb begin
      w_state_next = r_state;
      w_fetch_st   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_state_next = ST_FETCH;
         end
         ST_FETCH: begin
            w_state_next = ST_FETCH;
            w_fetch_st   = 1'b1;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Fetch decision and memory drive. A full buffer may still accept a word
   // when the head leaves in the same cycle, which keeps 1 instr/cycle.
   always_comb begin
      w_pop          = if_valid & id_ready;
      w_in_range     = {2'b00, r_fpc[31:2]} < MEM_WORDS_C;
      w_fetch_ok     = w_fetch_st & ~redirect_valid & ((r_count < DEPTH_C) | w_pop);
      imem_ce        = w_fetch_ok & w_in_range;
      imem_addr      = imem_ce ? r_fpc : 32'h0000_0000;
      w_push_inst    = w_in_range ? imem_inst : NOP_INST;
      // Low target bits are dropped: misaligned redirects are silently aligned.
      w_redir_target = redirect_pc & 32'hFFFF_FFFC;
   end

   // Fetch PC and FIFO bookkeeping; a redirect discards everything buffered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fpc    <= RESET_PC;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (redirect_valid) begin
         r_fpc    <= w_redir_target;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_fetch_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_fpc    <= r_fpc + 32'd4;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_fetch_ok, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Buffer storage: write the fetched pair at the tail. Contents need no
   // reset because the count alone says which entries are meaningful.
   always_ff @(posedge clk) begin
      if (!rst && w_fetch_ok) begin
         r_buf_pc[r_wr_ptr]   <= r_fpc;
         r_buf_inst[r_wr_ptr] <= w_push_inst;
      end
   end

   // Head presentation straight from buffer registers, zeroed when empty.
   always_comb begin
      if_valid = (r_count != '0);
      if_pc    = if_valid ? r_buf_pc[r_rd_ptr]   : 32'h0000_0000;
      if_inst  = if_valid ? r_buf_inst[r_rd_ptr] : 32'h0000_0000;
   end

   // Track the last delivered PC so consecutive pops can be checked for +4.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_chk_vld <= 1'b0;
         r_chk_pc  <= 32'h0000_0000;
      end else begin
         if (w_pop) begin
            if (r_chk_vld) begin
               assert (if_pc == r_chk_pc + 32'd4);
            end
            r_chk_pc  <= if_pc;
            r_chk_vld <= 1'b1;
         end
         if (redirect_valid) begin
            r_chk_vld <= 1'b0;
         end
      end
   end

   a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= DEPTH_C);
   a_addr_align:  assert property (@(posedge clk) disable iff (rst) imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed scenarios plus randomized traffic. The stimulus
// pushes the start PC of every new instruction stream (reset or redirect) into
// a queue; a monitor consumes that queue and checks each delivered {pc, inst}
// against a sequential-stream reference model.
module tb_if_fetch_ctrl;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          DEPTH     = 2;
   localparam int          MEM_WORDS = 1001;
   localparam logic [31:0] NOP_INST  = 32'h0000_0013;
   localparam logic [31:0] MEM_W     = 32'(MEM_WORDS);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_ce;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_ready = 1'b1;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;

   int          checks   = 0;
   int          failures = 0;
   int          n_pops   = 0;
   logic [31:0] seg_q[$];

   if_fetch_ctrl #(
      .RESET_PC  (RESET_PC),
      .DEPTH     (DEPTH),
      .MEM_WORDS (MEM_WORDS),
      .NOP_INST  (NOP_INST)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_ce        (imem_ce),
      .imem_addr      (imem_addr),
      .imem_inst      (imem_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_pc          (if_pc)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: word i holds 0x100+i. Reads while disabled
   // or beyond the array return junk so a misuse shows up in the stream.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      logic [31:0] idx;
      idx = addr >> 2;
      if (idx < MEM_W) return 32'h100 + idx;
      return 32'hBAD0_0BAD;
   endfunction

   assign imem_inst = imem_ce ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   // Reference: what decode must receive for a given PC.
   function automatic logic [31:0] ref_inst(input logic [31:0] pc);
      logic [31:0] idx;
      idx = pc >> 2;
      if (idx < MEM_W) return 32'h100 + idx;
      return NOP_INST;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // One cycle of stimulus: drive just after the edge, return at a settled point.
   task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
      @(posedge clk);
      #1;
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      id_ready       = rdy;
      if (r) seg_q.push_back(RESET_PC);
      else if (rv) seg_q.push_back(rpc);
      #2;
   endtask

   // Monitor / scoreboard: expected stream is sequential from the latest
   // stream start; the pop in a redirect cycle still belongs to the old stream.
   initial begin
      logic [31:0] exp_pc;
      logic [31:0] tmp;
      logic        exp_ok;
      logic        prev_stall;
      logic [31:0] prev_pc;
      logic [31:0] prev_inst;
      exp_pc     = 32'h0;
      exp_ok     = 1'b0;
      prev_stall = 1'b0;
      prev_pc    = 32'h0;
      prev_inst  = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
            if (seg_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL seg_queue: got empty expected reset entry at %0t", $time);
            end else begin
               exp_pc = seg_q.pop_front();
               exp_ok = 1'b1;
            end
         end else begin
            chk("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
            if (!imem_ce) chk("addr_gated", imem_addr, 32'h0);
            if (!if_valid) begin
               chk("empty_pc", if_pc, 32'h0);
               chk("empty_inst", if_inst, 32'h0);
            end
            if (prev_stall) begin
               chk("stall_valid", {31'h0, if_valid}, 32'h1);
               chk("stall_pc", if_pc, prev_pc);
               chk("stall_inst", if_inst, prev_inst);
            end
            if (if_valid && id_ready && exp_ok) begin
               $display("pop pc=%h inst=%h", if_pc, if_inst);
               chk("pop_pc", if_pc, exp_pc);
               chk("pop_inst", if_inst, ref_inst(exp_pc));
               exp_pc = exp_pc + 32'd4;
               n_pops++;
            end
            if (redirect_valid) begin
               if (seg_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL seg_queue: got empty expected redirect entry at %0t", $time);
               end else begin
                  tmp    = seg_q.pop_front();
                  exp_pc = {tmp[31:2], 2'b00};
               end
            end
            prev_stall = if_valid && !id_ready && !redirect_valid;
            prev_pc    = if_pc;
            prev_inst  = if_inst;
         end
      end
   end

   initial begin
      logic [31:0] tgt;
      logic        r;
      logic        rv;

      // Reset state and first fetch latency.
      repeat (3) drive(1'b1, 1'b0, 32'h0, 1'b1);
      chk("rst_ce", {31'h0, imem_ce}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'h0, if_valid}, 32'h0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_inst", if_inst, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("idle_ce", {31'h0, imem_ce}, 32'h0);
      chk("idle_valid", {31'h0, if_valid}, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("first_ce", {31'h0, imem_ce}, 32'h1);
      chk("first_addr", imem_addr, 32'h0);
      chk("first_valid", {31'h0, if_valid}, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("head_valid", {31'h0, if_valid}, 32'h1);
      chk("head_pc", if_pc, 32'h0);
      chk("head_inst", if_inst, 32'h100);
      chk("head_addr", imem_addr, 32'h4);
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         chk("stream_valid", {31'h0, if_valid}, 32'h1);
         chk("stream_pc", if_pc, 32'(4 + 4 * k));
         chk("stream_addr", imem_addr, 32'(8 + 4 * k));
      end

      // Back-pressure: fill, hold, then drain back-to-back.
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("stall0_addr", imem_addr, 32'h4);
      chk("stall0_pc", if_pc, 32'h0);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0);
         chk("full_ce", {31'h0, imem_ce}, 32'h0);
         chk("full_pc", if_pc, 32'h0);
         chk("full_inst", if_inst, 32'h100);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("release_addr", imem_addr, 32'h8);
      chk("release_pc", if_pc, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("release_pc1", if_pc, 32'h4);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("release_pc2", if_pc, 32'h8);

      // Redirect while full: head still pops, buffer flushed, target next.
      repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("prefull_ce", {31'h0, imem_ce}, 32'h0);
      drive(1'b0, 1'b1, 32'h40, 1'b1);
      chk("redir_ce", {31'h0, imem_ce}, 32'h0);
      chk("redir_valid", {31'h0, if_valid}, 32'h1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("redir_flush", {31'h0, if_valid}, 32'h0);
      chk("redir_addr", imem_addr, 32'h40);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("redir_pc", if_pc, 32'h40);
      chk("redir_inst", if_inst, 32'h110);

      // Misaligned target, then back-to-back redirects.
      drive(1'b0, 1'b1, 32'h46, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("align_addr", imem_addr, 32'h44);
      drive(1'b0, 1'b1, 32'h80, 1'b1);
      drive(1'b0, 1'b1, 32'hC0, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("b2b_addr", imem_addr, 32'hC0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("b2b_pc", if_pc, 32'hC0);

      // End of implemented memory.
      drive(1'b0, 1'b1, 32'hF9C, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("edge_addr0", imem_addr, 32'hF9C);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("edge_addr1", imem_addr, 32'hFA0);
      chk("edge_inst0", if_inst, 32'h4E7);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("oor_ce", {31'h0, imem_ce}, 32'h0);
      chk("edge_inst1", if_inst, 32'h4E8);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("oor_pc", if_pc, 32'hFA4);
      chk("oor_inst", if_inst, NOP_INST);

      // 32-bit wrap of the fetch PC.
      drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_ce", {31'h0, imem_ce}, 32'h1);

      // Reset beats a redirect while full.
      repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b1, 32'h200, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("rst_redir_valid", {31'h0, if_valid}, 32'h0);
      chk("rst_redir_ce", {31'h0, imem_ce}, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("restart_addr", imem_addr, RESET_PC);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("restart_pc", if_pc, RESET_PC);
      chk("restart_inst", if_inst, 32'h100);

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         r  = ($urandom_range(0, 199) == 0);
         rv = ($urandom_range(0, 99) < 6);
         case ($urandom_range(0, 3))
            0:       tgt = 32'($urandom_range(0, 1100)) * 32'd4 + 32'($urandom_range(0, 3));
            1:       tgt = 32'hF90 + 32'($urandom_range(0, 7)) * 32'd4;
            2:       tgt = $urandom;
            default: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         endcase
         drive(r, rv, tgt, ($urandom_range(0, 99) < 65));
      end
      repeat (4) drive(1'b0, 1'b0, 32'h0, 1'b1);

      chk("seg_drained", 32'(seg_q.size()), 32'h0);
      chk("pop_activity", {31'h0, (n_pops > 300)}, 32'h1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
